// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and types
// Purpose: machine width, default debug starvation limit and the dmem
//          arbiter ownership encoding shared by the memory-stage blocks.
// Ports:   none (package).
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bundle of CPU, debug and dmem port signals
// Purpose: groups the CPU MEM-stage port, the debug/loader port and the
//          data memory port that meet at the dmem arbiter.
// Ports:   master - requesters and memory (drive requests, mem_rdata)
//          slave  - the arbiter (drives grants, responses, mem command)
interface dmem_arbiter_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            cpu_req;
  logic            cpu_we;
  logic [XLEN-1:0] cpu_addr;
  logic [XLEN-1:0] cpu_wdata;
  logic [XLEN-1:0] cpu_rdata;
  logic            cpu_stall;

  logic            dbg_req;
  logic            dbg_we;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_gnt;
  logic            dbg_rvalid;
  logic [XLEN-1:0] dbg_rdata;

  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic            addr_err;
  logic [15:0]     stall_cnt;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  addr_err, stall_cnt
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output addr_err, stall_cnt
  );

endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / debug arbiter in front of the data memory
// Purpose: per-cycle combinational arbitration of the CPU MEM-stage port and
//          the debug port onto one dmem port; CPU has priority unless the
//          debug port has lost STARVE_MAX cycles in a row.
// Ports:   clk        - single clock, rising edge
//          rst        - asynchronous, active-low reset
//          bus.slave  - cpu_* (request, stall, zero-latency read data),
//                       dbg_* (request, grant, registered read response),
//                       mem_* (combinational read, synchronous write),
//                       addr_err (out-of-range pulse), stall_cnt
module dmem_arbiter #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = riscv_pkg::STARVE_MAX
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave bus
);

  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);
  // A limit of zero still needs a one-bit counter.
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_owner_e      owner;
  logic [SW-1:0]   starve_cnt;
  logic            starved;
  logic            own_we;
  logic [XLEN-1:0] own_addr;
  logic [XLEN-1:0] own_wdata;
  logic [AW-1:0]   word_idx;
  logic            in_range;
  logic            cpu_stall;
  logic            dbg_rd_gnt;

  logic            dbg_rvalid_q;
  logic [XLEN-1:0] dbg_rdata_q;
  logic            addr_err_q;
  logic [15:0]     stall_cnt_q;

  always_comb begin
    starved   = bus.dbg_req && (starve_cnt == SW'(STARVE_MAX));
    owner     = OWN_NONE;
    if (bus.cpu_req && !starved) begin
      owner = OWN_CPU;
    end else if (bus.dbg_req) begin
      owner = OWN_DBG;
    end

    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    unique case (owner)
      OWN_CPU: begin
        own_we    = bus.cpu_we;
        own_addr  = bus.cpu_addr;
        own_wdata = bus.cpu_wdata;
      end
      OWN_DBG: begin
        own_we    = bus.dbg_we;
        own_addr  = bus.dbg_addr;
        own_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  // Byte offset bits are ignored; any set bit above the word index is out of range.
  assign word_idx   = own_addr[AW+1:2];
  assign in_range   = (32'(word_idx) < DEPTH) && (own_addr[XLEN-1:AW+2] == '0);
  assign cpu_stall  = bus.cpu_req && (owner != OWN_CPU);
  assign dbg_rd_gnt = (owner == OWN_DBG) && !bus.dbg_we;

  assign bus.mem_we     = own_we && in_range;
  assign bus.mem_addr   = own_addr;
  assign bus.mem_wdata  = own_wdata;
  assign bus.cpu_rdata  = ((owner == OWN_CPU) && !bus.cpu_we && in_range) ? bus.mem_rdata : '0;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.dbg_gnt    = (owner == OWN_DBG);
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.stall_cnt  = stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      addr_err_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      // Counts consecutive debug losses; any win or idle cycle restarts it.
      if (bus.dbg_req && (owner != OWN_DBG)) begin
        if (starve_cnt != SW'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      dbg_rvalid_q <= dbg_rd_gnt;
      // Read data is captured at grant and held until the next debug read.
      if (dbg_rd_gnt) begin
        dbg_rdata_q <= in_range ? bus.mem_rdata : '0;
      end

      addr_err_q <= (owner != OWN_NONE) && !in_range;

      if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule
